// File: rtl/parity_stream_checker.sv
// Parity checker for a single word stream: flags bad words, keeps statistics and
// escalates OK -> SUSPECT -> FAULT on a run of consecutive parity errors.
module parity_stream_checker #(
  parameter int DATA_W = 6,
  parameter int ODD    = 0,
  parameter int THRESH = 3,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              clr,
  output logic              out_valid,
  output logic [DATA_W-2:0] out_data,
  output logic              out_error,
  output logic              sticky_err,
  output logic              fault,
  output logic [CNT_W-1:0]  word_cnt,
  output logic [CNT_W-1:0]  err_cnt
);

  typedef enum logic [1:0] {S_OK = 2'd0, S_SUSPECT = 2'd1, S_FAULT = 2'd2} state_t;

  localparam logic [7:0]       THR8    = 8'(THRESH);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic             FLIP    = (ODD != 0);

  state_t     state, state_nxt;
  logic [7:0] consec, consec_nxt, consec_inc;
  logic       err, acc, acc_err;

  assign err        = (^in_data) ^ FLIP;
  // clr wins: a word seen alongside clr is reported but never counted
  assign acc        = in_valid & ~clr;
  assign acc_err    = acc & err;
  assign consec_inc = consec + 8'd1;

  // output stage: payload holds across idle cycles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_error <= 1'b0;
      out_data  <= '0;
    end else begin
      out_valid <= in_valid;
      out_error <= in_valid & err;
      if (in_valid) out_data <= in_data[DATA_W-2:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_cnt   <= '0;
      err_cnt    <= '0;
      sticky_err <= 1'b0;
    end else if (clr) begin
      word_cnt   <= '0;
      err_cnt    <= '0;
      sticky_err <= 1'b0;
    end else begin
      if (acc) word_cnt <= word_cnt + CNT_ONE;
      if (acc_err && (err_cnt != '1)) err_cnt <= err_cnt + CNT_ONE;
      if (acc_err) sticky_err <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_OK;
      consec <= '0;
    end else begin
      state  <= state_nxt;
      consec <= consec_nxt;
    end
  end

  // idle cycles fall through unchanged, so gaps do not break an error run
  always_comb begin
    state_nxt  = state;
    consec_nxt = consec;
    if (clr) begin
      state_nxt  = S_OK;
      consec_nxt = '0;
    end else if (acc) begin
      unique case (state)
        S_OK: begin
          if (err) begin
            consec_nxt = 8'd1;
            state_nxt  = (THR8 == 8'd1) ? S_FAULT : S_SUSPECT;
          end
        end
        S_SUSPECT: begin
          if (err) begin
            consec_nxt = consec_inc;
            if (consec_inc == THR8) state_nxt = S_FAULT;
          end else begin
            consec_nxt = '0;
            state_nxt  = S_OK;
          end
        end
        S_FAULT: state_nxt = S_FAULT;
        default: begin
          state_nxt  = S_OK;
          consec_nxt = '0;
        end
      endcase
    end
  end

  // decoded from the state flop only, so no input reaches fault combinationally
  always_comb begin
    fault = (state == S_FAULT);
  end

endmodule

// File: tb/tb_parity_stream_checker.sv
// Four checker instances (default, odd parity, 4-bit counters, THRESH=1) fed the same
// stream and compared every cycle against an error-run model plus literal expectations.
module tb_parity_stream_checker;

  localparam int N = 4;
  localparam int P_ODD [N] = '{0, 1, 0, 0};
  localparam int P_THR [N] = '{3, 3, 3, 1};
  localparam int P_CW  [N] = '{8, 8, 4, 8};

  logic       clk = 1'b0;
  logic       rst_n, in_valid, clr;
  logic [5:0] in_data;

  logic       ov [N], oe [N], se [N], ft [N];
  logic [4:0] od [N];
  logic [7:0] wc [N], ec [N];
  logic [3:0] wc2, ec2;

  int checks   = 0;
  int failures = 0;
  bit done     = 1'b0;

  // model state
  bit       m_ov [N], m_oe [N], m_se [N], m_ft [N];
  bit [4:0] m_od [N];
  int       m_wc [N], m_ec [N], m_run [N];

  always #5 clk = ~clk;

  parity_stream_checker u0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .clr(clr),
    .out_valid(ov[0]), .out_data(od[0]), .out_error(oe[0]), .sticky_err(se[0]),
    .fault(ft[0]), .word_cnt(wc[0]), .err_cnt(ec[0]));

  parity_stream_checker #(.ODD(1)) u1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .clr(clr),
    .out_valid(ov[1]), .out_data(od[1]), .out_error(oe[1]), .sticky_err(se[1]),
    .fault(ft[1]), .word_cnt(wc[1]), .err_cnt(ec[1]));

  parity_stream_checker #(.CNT_W(4)) u2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .clr(clr),
    .out_valid(ov[2]), .out_data(od[2]), .out_error(oe[2]), .sticky_err(se[2]),
    .fault(ft[2]), .word_cnt(wc2), .err_cnt(ec2));

  parity_stream_checker #(.THRESH(1)) u3 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .clr(clr),
    .out_valid(ov[3]), .out_data(od[3]), .out_error(oe[3]), .sticky_err(se[3]),
    .fault(ft[3]), .word_cnt(wc[3]), .err_cnt(ec[3]));

  assign wc[2] = {4'h0, wc2};
  assign ec[2] = {4'h0, ec2};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a word is bad when its ones-count parity disagrees with the mode; fault
  // latches once THRESH bad words arrive with no good word between them.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) begin
        m_ov[i] <= 0; m_oe[i] <= 0; m_se[i] <= 0; m_ft[i] <= 0;
        m_od[i] <= '0; m_wc[i] <= 0; m_ec[i] <= 0; m_run[i] <= 0;
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        bit e;
        int run_n, lim;
        bit ft_n;
        e     = (($countones(in_data) % 2) != P_ODD[i]);
        lim   = (1 << P_CW[i]) - 1;
        run_n = m_run[i];
        ft_n  = m_ft[i];
        m_ov[i] <= in_valid;
        m_oe[i] <= in_valid && e;
        if (in_valid) m_od[i] <= in_data[4:0];
        if (clr) begin
          m_wc[i] <= 0; m_ec[i] <= 0; m_se[i] <= 0; m_run[i] <= 0; m_ft[i] <= 0;
        end else if (in_valid) begin
          m_wc[i] <= (m_wc[i] + 1) % (lim + 1);
          if (e) begin
            m_ec[i] <= (m_ec[i] < lim) ? m_ec[i] + 1 : lim;
            m_se[i] <= 1;
            if (!ft_n) begin
              run_n++;
              if (run_n >= P_THR[i]) ft_n = 1;
            end
          end else if (!ft_n) begin
            run_n = 0;
          end
          m_run[i] <= run_n;
          m_ft[i]  <= ft_n;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!done) begin
      for (int i = 0; i < N; i++) begin
        chk($sformatf("u%0d.out_valid", i), 64'(ov[i]), 64'(m_ov[i]));
        chk($sformatf("u%0d.out_error", i), 64'(oe[i]), 64'(m_oe[i]));
        chk($sformatf("u%0d.out_data", i), 64'(od[i]), 64'(m_od[i]));
        chk($sformatf("u%0d.sticky_err", i), 64'(se[i]), 64'(m_se[i]));
        chk($sformatf("u%0d.fault", i), 64'(ft[i]), 64'(m_ft[i]));
        chk($sformatf("u%0d.word_cnt", i), 64'(wc[i]), 64'(m_wc[i]));
        chk($sformatf("u%0d.err_cnt", i), 64'(ec[i]), 64'(m_ec[i]));
      end
    end
  end

  task automatic step(input logic v, input logic [5:0] d, input logic c);
    in_valid = v; in_data = d; clr = c;
    @(negedge clk);
  endtask

  task automatic chk_all_zero(input string tag);
    for (int i = 0; i < N; i++) begin
      chk($sformatf("%s.u%0d.ov", tag, i), 64'(ov[i]), 64'd0);
      chk($sformatf("%s.u%0d.od", tag, i), 64'(od[i]), 64'd0);
      chk($sformatf("%s.u%0d.oe", tag, i), 64'(oe[i]), 64'd0);
      chk($sformatf("%s.u%0d.se", tag, i), 64'(se[i]), 64'd0);
      chk($sformatf("%s.u%0d.ft", tag, i), 64'(ft[i]), 64'd0);
      chk($sformatf("%s.u%0d.wc", tag, i), 64'(wc[i]), 64'd0);
      chk($sformatf("%s.u%0d.ec", tag, i), 64'(ec[i]), 64'd0);
    end
  endtask

  logic [5:0] mix [8] = '{6'b010101, 6'b111111, 6'b000000, 6'b100001,
                          6'b011100, 6'b110110, 6'b001011, 6'b101000};

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; clr = 1'b0;
    #3 chk_all_zero("reset");
    @(negedge clk); rst_n = 1'b1;

    // good word, even mode
    step(1, 6'b000011, 0);
    chk("lit.good.ov", 64'(ov[0]), 64'd1);
    chk("lit.good.oe", 64'(oe[0]), 64'd0);
    chk("lit.good.od", 64'(od[0]), 64'h03);
    chk("lit.good.wc", 64'(wc[0]), 64'd1);

    // bad in even mode, good in odd mode, immediate fault at THRESH=1
    step(1, 6'b100011, 0);
    chk("lit.bad.oe", 64'(oe[0]), 64'd1);
    chk("lit.bad.se", 64'(se[0]), 64'd1);
    chk("lit.bad.ec", 64'(ec[0]), 64'd1);
    chk("lit.bad.ft", 64'(ft[0]), 64'd0);
    chk("lit.odd.oe", 64'(oe[1]), 64'd0);
    chk("lit.thr1.ft", 64'(ft[3]), 64'd1);

    step(0, 6'b111111, 0);
    chk("lit.idle.ov", 64'(ov[0]), 64'd0);
    chk("lit.idle.od_hold", 64'(od[0]), 64'h03);
    step(0, 6'b000000, 1);
    chk("lit.clr.se", 64'(se[0]), 64'd0);
    chk("lit.clr.thr1.ft", 64'(ft[3]), 64'd0);

    // bad, bad, good with gaps: run broken before THRESH
    step(1, 6'b100000, 0); step(0, 0, 0);
    step(1, 6'b000001, 0); step(0, 0, 0);
    step(1, 6'b000011, 0); step(0, 0, 0);
    chk("lit.run_break.ft", 64'(ft[0]), 64'd0);
    step(1, 6'b010000, 0);
    step(1, 6'b001000, 0);
    chk("lit.run2.ft", 64'(ft[0]), 64'd0);
    step(1, 6'b111000, 0);
    chk("lit.run3.ft", 64'(ft[0]), 64'd1);
    step(1, 6'b000000, 0);
    step(1, 6'b110000, 0);
    chk("lit.fault_sticks", 64'(ft[0]), 64'd1);
    step(0, 0, 1);
    chk("lit.fault_clr", 64'(ft[0]), 64'd0);

    // saturation of a 4-bit err_cnt and wrap of the 4-bit word_cnt
    for (int k = 0; k < 20; k++) step(1, 6'b000100, 0);
    chk("lit.sat.ec", 64'(ec[2]), 64'd15);
    chk("lit.sat.wc", 64'(wc[2]), 64'd4);
    chk("lit.sat.u0.ec", 64'(ec[0]), 64'd20);
    step(1, 6'b000100, 1);
    chk("lit.clrword.oe", 64'(oe[2]), 64'd1);
    chk("lit.clrword.ov", 64'(ov[2]), 64'd1);
    chk("lit.clrword.ec", 64'(ec[2]), 64'd0);
    chk("lit.clrword.wc", 64'(wc[2]), 64'd0);
    chk("lit.clrword.se", 64'(se[2]), 64'd0);
    chk("lit.clrword.ft", 64'(ft[2]), 64'd0);

    // mixed words with idles
    for (int k = 0; k < 8; k++) begin
      step(1, mix[k], 0);
      if (k % 3 == 2) step(0, 6'b101010, 0);
    end

    // async reset mid-cycle with a word in flight
    step(1, 6'b101010, 0);
    in_valid = 1'b1; in_data = 6'b011111;
    #2 rst_n = 1'b0;
    #1 chk_all_zero("midrst");
    in_valid = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    chk("lit.postrst.ov", 64'(ov[0]), 64'd0);
    chk("lit.postrst.wc", 64'(wc[0]), 64'd0);

    // first word after release, THRESH=1 faults at once
    step(1, 6'b000001, 0);
    chk("lit.postrst.first.wc", 64'(wc[0]), 64'd1);
    chk("lit.thr1b.ft", 64'(ft[3]), 64'd1);
    step(0, 0, 0);

    done = 1'b1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/parity_stream_checker.md
PARITY_STREAM_CHECKER -- requirements
Module: parity_stream_checker

Interface
REQ-001 Parameter DATA_W, default 6: word width including the parity bit, which is in_data[DATA_W-1]; legal range 2..64.
REQ-002 Parameter ODD, default 0: 0 selects even parity, 1 selects odd parity.
REQ-003 Parameter THRESH, default 3: consecutive-error count that enters FAULT; legal range 1..255.
REQ-004 Parameter CNT_W, default 8: width of both statistics counters.
REQ-005 clk  input  1  sole clock; all state updates on its rising edge.
REQ-006 rst_n  input  1  asynchronous, active-low reset.
REQ-007 in_valid  input  1  in_data holds a word this cycle.
REQ-008 in_data  input  DATA_W  word under check, parity bit at the MSB.
REQ-009 clr  input  1  synchronous clear of statistics, sticky flag and FSM.
REQ-010 out_valid  output  1  out_data and out_error are valid this cycle.
REQ-011 out_data  output  DATA_W-1  payload in_data[DATA_W-2:0] of the checked word.
REQ-012 out_error  output  1  the checked word failed parity.
REQ-013 sticky_err  output  1  at least one error since the last reset or clr.
REQ-014 fault  output  1  the FSM is in FAULT.
REQ-015 word_cnt  output  CNT_W  accepted words, modulo 2^CNT_W.
REQ-016 err_cnt  output  CNT_W  errored words, saturating.

Function
REQ-017 The parity error term shall be err = XOR of all DATA_W bits of in_data, XOR ODD (even mode: error when the bit-1 count is odd; odd mode: error when it is even).
REQ-018 A word shall be accepted when in_valid=1; the block has no backpressure and accepts every cycle.
REQ-019 Latency shall be exactly 1 cycle: out_valid, out_data and out_error are registered from the accepting cycle.
REQ-020 When in_valid=0, out_valid shall be 0, out_error 0, and out_data shall hold its previous value.
REQ-021 Each accepted word shall increment word_cnt, wrapping from all-ones to 0.
REQ-022 Each errored word shall increment err_cnt, which holds at all-ones once saturated.
REQ-023 sticky_err shall be set in the cycle after an errored word and remain set until clr or reset.
REQ-024 The FSM shall have three states, OK, SUSPECT and FAULT, plus an internal consecutive-error counter consec of 8 bits.
REQ-025 OK: an errored word sets consec=1 and goes to SUSPECT, or goes directly to FAULT when THRESH=1; a good word stays in OK.
REQ-026 SUSPECT: an errored word increments consec and goes to FAULT when the new consec equals THRESH; a good word clears consec and returns to OK.
REQ-027 FAULT shall be absorbing: it is left only by clr or reset, and word processing and counters continue while in it.
REQ-028 Cycles with in_valid=0 shall not change consec or the FSM state; they do not break an error run.
REQ-029 clr=1 shall clear word_cnt, err_cnt, sticky_err and consec, and force OK, on the next edge.
REQ-030 clr has priority: a word accepted in the same cycle as clr still produces out_valid/out_error, but is not counted, does not set sticky_err and does not advance the FSM.
REQ-031 fault shall be a registered decode of state==FAULT with no combinational path from inputs.

Reset
REQ-032 rst_n=0 shall immediately force out_valid=0, out_data=0, out_error=0, sticky_err=0, fault=0, word_cnt=0, err_cnt=0, consec=0 and state OK.
REQ-033 Reset asserted mid-stream shall discard any in-flight word, so no out_valid appears for it after release.
REQ-034 After rst_n deassertion, the first word shall be accepted on the first rising edge at which in_valid=1.

Verification
REQ-035 Default params, in_data=6'b000011, valid 1 cycle -> next cycle out_valid=1, out_error=0, out_data=5'b00011, word_cnt=1.
REQ-036 Default params, in_data=6'b100011 -> out_error=1, sticky_err=1, err_cnt=1, FSM in SUSPECT; with ODD=1 the same word -> out_error=0.
REQ-037 Errored, errored, good (idle cycles between the words) -> FSM back in OK and fault=0; then 3 errored words back-to-back -> fault=1 one cycle after the third word, and it stays 1 across later good words.
REQ-038 CNT_W=4, 20 errored words -> err_cnt=15 and word_cnt=4; then clr together with a valid errored word -> out_error=1, all counters 0, sticky_err=0, fault=0.
REQ-039 rst_n pulsed low mid-cycle while in_valid=1 -> all outputs 0 immediately and no out_valid after release; THRESH=1 with a single errored word -> fault=1 on the next cycle.
